frame_streamer: RTL

Raster-order pixel source that reads a 160x120, 24-bit frame from a synchronous-read frame memory and emits a pixel stream (`pixel_out`, `pixel_addr`, `valid_out`) that drives the neighborhood line buffer of the filter pipeline. It sits between the frame RAM read port and the filter front end. It owns read-address generation, compensates for memory read latency, and frames the stream with start-of-frame and end-of-line markers. It has no downstream backpressure; a `pause` input only gates new memory reads.

---
 rtl/frame_pkg.sv | 18 +
 rtl/rd_lat_pipe.sv | 30 +++
 rtl/frame_streamer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared frame geometry and FSM encoding for the frame streamer, filter and writeback blocks.
package frame_pkg;

  localparam int FRAME_W      = 160;
  localparam int FRAME_H      = 120;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int PIX_W        = 24;
  localparam int ADDR_W       = 15;
  localparam int X_W          = $clog2(FRAME_W);
  localparam int Y_W          = $clog2(FRAME_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } frame_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Fixed-depth delay line that carries per-read sideband alongside the frame-memory latency.
module rd_lat_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [W-1:0] stage_d;
    logic [W-1:0] stage_q;

    if (gi == 0) begin : g_first
      assign stage_d = d_i;
    end else begin : g_next
      assign stage_d = g_stage[gi-1].stage_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) stage_q <= '0;
      else     stage_q <= stage_d;
    end
  end

  assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/frame_streamer.sv
// Raster-order frame reader: issues row-major reads, re-aligns sideband with the read
// latency and emits a framed pixel stream with sof/eol/done markers.
module frame_streamer
  import frame_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  pixel_out,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              valid_out,
  output logic              sof,
  output logic              eol,
  output logic              busy,
  output logic              done
);

  localparam int PIPE_W = ADDR_W + 3;
  localparam logic [X_W-1:0]    X_LAST    = X_W'(FRAME_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(FRAME_H - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);

  frame_state_e      state_q, state_d;
  logic [X_W-1:0]    x_q, x_d, cur_x;
  logic [Y_W-1:0]    y_q, y_d, cur_y;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_addr;
  logic              issue, last_issue;

  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              mem_sof_q, mem_sof_d;
  logic              mem_eol_q, mem_eol_d;

  logic [PIPE_W-1:0] pipe_out;
  logic              p_valid, p_sof, p_eol;
  logic [ADDR_W-1:0] p_addr;

  logic [PIX_W-1:0]  pixel_out_q, pixel_out_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              done_q, done_d;

  // The start edge itself issues address 0, so IDLE presents cleared counters directly.
  always_comb begin
    cur_x      = (state_q == ST_IDLE) ? '0 : x_q;
    cur_y      = (state_q == ST_IDLE) ? '0 : y_q;
    cur_addr   = (state_q == ST_IDLE) ? '0 : addr_q;
    issue      = !pause && (((state_q == ST_IDLE) && start) || (state_q == ST_ISSUE));
    last_issue = issue && (cur_x == X_LAST) && (cur_y == Y_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // DRAIN is held through the done cycle so a start coinciding with done is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = last_issue ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (done_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d           = cur_x;
    y_d           = cur_y;
    addr_d        = cur_addr;
    mem_rd_en_d   = issue;
    mem_rd_addr_d = mem_rd_addr_q;
    mem_sof_d     = mem_sof_q;
    mem_eol_d     = mem_eol_q;
    if (issue) begin
      mem_rd_addr_d = cur_addr;
      mem_sof_d     = (cur_addr == '0);
      mem_eol_d     = (cur_x == X_LAST);
      addr_d        = cur_addr + 1'b1;
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = cur_y + 1'b1;
      end else begin
        x_d = cur_x + 1'b1;
      end
    end

    valid_d      = p_valid;
    pixel_out_d  = pixel_out_q;
    pixel_addr_d = pixel_addr_q;
    sof_d        = p_valid && p_sof;
    eol_d        = p_valid && p_eol;
    done_d       = p_valid && (p_addr == ADDR_LAST);
    if (p_valid) begin
      pixel_out_d  = mem_rd_data;
      pixel_addr_d = p_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_sof_q     <= 1'b0;
      mem_eol_q     <= 1'b0;
      pixel_out_q   <= '0;
      pixel_addr_q  <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_sof_q     <= mem_sof_d;
      mem_eol_q     <= mem_eol_d;
      pixel_out_q   <= pixel_out_d;
      pixel_addr_q  <= pixel_addr_d;
      valid_q       <= valid_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      done_q        <= done_d;
    end
  end

  // The issue register counts as the read cycle; the pipe adds RD_LAT more to meet the data.
  rd_lat_pipe #(
    .DEPTH (RD_LAT),
    .W     (PIPE_W)
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .d_i ({mem_rd_en_q, mem_rd_addr_q, mem_sof_q, mem_eol_q}),
    .q_o (pipe_out)
  );

  assign {p_valid, p_addr, p_sof, p_eol} = pipe_out;

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign pixel_out   = pixel_out_q;
  assign pixel_addr  = pixel_addr_q;
  assign valid_out   = valid_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
